// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   Executes MULT/MULTU (MUL_STEP multiplier bits per cycle), DIV/DIVU
//   (restoring radix-2, one quotient bit per cycle) and the MTHI/MTLO moves.
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start_i, funct_i   issue request and R-type funct, sampled only in IDLE
//   rs_i, rt_i         operands (multiplicand/dividend, multiplier/divisor)
//   abort_i            exception flush; drops an in-flight op without writeback
//   busy_o             high while an operation occupies the unit
//   done_o             one-cycle pulse, HI/LO just written by a MULT/DIV
//   div_by_zero_o      qualifies done_o: the division had a zero divisor
//   hi_o, lo_o         HI and LO registers
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STEP   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [5:0]            funct_i,
  input  logic [DATA_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0] rt_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W     = DATA_WIDTH;
  localparam int N_MUL = W / MUL_STEP;
  localparam int CW    = $clog2(W);
  localparam logic [CW-1:0] C_MUL_LAST = CW'(N_MUL - 1);
  localparam logic [CW-1:0] C_DIV_LAST = CW'(W - 1);

  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t          r_state, w_next;
  // Shared accumulator. MUL: {partial product high, remaining multiplier bits}.
  // DIV: {partial remainder, dividend bits shifting out / quotient bits in}.
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_mcand;   // multiplicand or divisor magnitude
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q, r_neg_r, r_is_div, r_dbz;
  logic            r_done, r_dbz_o;
  logic [W-1:0]    r_hi, r_lo;

  logic            w_go, w_is_mul, w_is_div, w_signed, w_rs_neg, w_rt_neg, w_rt_zero;
  logic [W-1:0]    w_rs_mag, w_rt_mag, w_hi_raw, w_lo_raw;
  logic [W+MUL_STEP-1:0] w_pp, w_msum;
  logic [2*W-1:0]  w_mul_next, w_div_next;
  logic [W:0]      w_trial;

  // Issue decode; an abort in the same cycle suppresses every start.
  assign w_go      = (r_state == S_IDLE) && start_i && !abort_i;
  assign w_is_mul  = (funct_i == F_MULT) || (funct_i == F_MULTU);
  assign w_is_div  = (funct_i == F_DIV)  || (funct_i == F_DIVU);
  assign w_signed  = (funct_i == F_MULT) || (funct_i == F_DIV);
  assign w_rs_neg  = w_signed && rs_i[W-1];
  assign w_rt_neg  = w_signed && rt_i[W-1];
  assign w_rs_mag  = w_rs_neg ? -rs_i : rs_i;
  assign w_rt_mag  = w_rt_neg ? -rt_i : rt_i;
  assign w_rt_zero = (rt_i == '0);

  // Multiply step: add multiplicand x low MUL_STEP multiplier bits into the
  // upper half, then shift the whole accumulator right by MUL_STEP. The sum
  // never exceeds W+MUL_STEP bits, so nothing is lost.
  assign w_pp       = {{MUL_STEP{1'b0}}, r_mcand} * {{W{1'b0}}, r_acc[MUL_STEP-1:0]};
  assign w_msum     = {{MUL_STEP{1'b0}}, r_acc[2*W-1:W]} + w_pp;
  assign w_mul_next = (2*W)'({w_msum, r_acc[W-1:0]} >> MUL_STEP);

  // Restoring divide step: trial-subtract the divisor from the shifted
  // remainder; keep the difference and set the quotient bit if it did not borrow.
  assign w_trial    = r_acc[2*W-1:W-1] - {1'b0, r_mcand};
  assign w_div_next = w_trial[W] ? {r_acc[2*W-2:0], 1'b0}
                                 : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_hi_raw = r_acc[2*W-1:W];
  assign w_lo_raw = r_acc[W-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_go) begin
        if (w_is_mul)      w_next = S_MUL;
        else if (w_is_div) w_next = w_rt_zero ? S_FIX : S_DIV;
      end
      S_MUL:  if (abort_i) w_next = S_IDLE; else if (r_cnt == '0) w_next = S_FIX;
      S_DIV:  if (abort_i) w_next = S_IDLE; else if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
      r_dbz_o  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done  <= (r_state == S_FIX) && !abort_i;
      r_dbz_o <= (r_state == S_FIX) && !abort_i && r_dbz;
      case (r_state)
        S_IDLE: if (w_go) begin
          if (funct_i == F_MTHI) r_hi <= rs_i;
          if (funct_i == F_MTLO) r_lo <= rs_i;
          if (w_is_mul) begin
            r_acc    <= {{W{1'b0}}, w_rt_mag};
            r_mcand  <= w_rs_mag;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= C_MUL_LAST;
          end else if (w_is_div) begin
            r_is_div <= 1'b1;
            r_cnt    <= C_DIV_LAST;
            if (w_rt_zero) begin
              // Preload the fixed result; FIX passes it through unsigned.
              r_acc   <= {rs_i, {W{1'b1}}};
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_dbz   <= 1'b1;
            end else begin
              r_acc   <= {{W{1'b0}}, w_rs_mag};
              r_mcand <= w_rt_mag;
              r_neg_q <= w_rs_neg ^ w_rt_neg;
              r_neg_r <= w_rs_neg;
              r_dbz   <= 1'b0;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: if (!abort_i) begin
          if (r_is_div) begin
            r_lo <= r_neg_q ? -w_lo_raw : w_lo_raw;
            r_hi <= r_neg_r ? -w_hi_raw : w_hi_raw;
          end else begin
            // Product is negated as one 2W-bit value.
            {r_hi, r_lo} <= r_neg_q ? -r_acc : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign div_by_zero_o = r_dbz_o;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Testbench for mips_muldiv_unit: three instances (MUL_STEP 2/1/4) share
// inputs; results are checked against a plain-arithmetic model.
module tb_mips_muldiv_unit;
  logic        clk = 1'b0, rst, start, abort;
  logic [5:0]  funct;
  logic [31:0] rs, rt;
  logic        busy, done, dbz, busy1, done1, dbz1, busy4, done4, dbz4;
  logic [31:0] hi, lo, hi1, lo1, hi4, lo4;
  int checks = 0, failures = 0;

  mips_muldiv_unit #(.DATA_WIDTH(32), .MUL_STEP(2)) dut (
    .clk(clk), .rst(rst), .start_i(start), .funct_i(funct), .rs_i(rs), .rt_i(rt),
    .abort_i(abort), .busy_o(busy), .done_o(done), .div_by_zero_o(dbz), .hi_o(hi), .lo_o(lo));
  mips_muldiv_unit #(.DATA_WIDTH(32), .MUL_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .funct_i(funct), .rs_i(rs), .rt_i(rt),
    .abort_i(abort), .busy_o(busy1), .done_o(done1), .div_by_zero_o(dbz1), .hi_o(hi1), .lo_o(lo1));
  mips_muldiv_unit #(.DATA_WIDTH(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start), .funct_i(funct), .rs_i(rs), .rt_i(rt),
    .abort_i(abort), .busy_o(busy4), .done_o(done4), .div_by_zero_o(dbz4), .hi_o(hi4), .lo_o(lo4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics from 64-bit arithmetic.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    ed = 1'b0;
    case (f)
      6'd24: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      6'd25: begin u = {32'd0, a} * {32'd0, b}; eh = u[63:32]; el = u[31:0]; end
      default:
        if (b == 0) begin ed = 1'b1; eh = a; el = 32'hFFFF_FFFF; end
        else if (f == 6'd26) begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
        else begin eh = a % b; el = a / b; end
    endcase
  endfunction

  task automatic wait_idle();
    for (int c = 0; c < 80 && (busy | busy1 | busy4); c++) @(negedge clk);
    if (busy | busy1 | busy4) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic ed, ismul, b0, bd, dz;
    int lat, l1, l4, le, l1e, l4e;
    model(f, a, b, eh, el, ed);
    ismul = (f == 6'd24) || (f == 6'd25);
    le  = ed ? 1 : (ismul ? 17 : 33);
    l1e = ed ? 1 : 33;
    l4e = ed ? 1 : (ismul ? 9 : 33);
    wait_idle();
    funct = f; rs = a; rt = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b0 = busy;
    lat = -1; l1 = -1; l4 = -1; bd = 1'b1; dz = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (lat > 0 && c == lat + 1) chk({tag, "_done_1cyc"}, {63'd0, done}, 0);
      if (done && lat < 0) begin lat = c; bd = busy; dz = dbz; end
      if (done1 && l1 < 0) l1 = c;
      if (done4 && l4 < 0) l4 = c;
      if (lat >= 0 && l1 >= 0 && l4 >= 0 && c > lat) break;
    end
    chk({tag, "_busy0"}, {63'd0, b0}, 1);
    chk({tag, "_lat"}, 64'(lat), 64'(le));
    chk({tag, "_lat1"}, 64'(l1), 64'(l1e));
    chk({tag, "_lat4"}, 64'(l4), 64'(l4e));
    chk({tag, "_busy_done"}, {63'd0, bd}, 0);
    chk({tag, "_dbz"}, {63'd0, dz}, {63'd0, ed});
    chk({tag, "_hilo"}, {hi, lo}, {eh, el});
    chk({tag, "_hilo1"}, {hi1, lo1}, {eh, el});
    chk({tag, "_hilo4"}, {hi4, lo4}, {eh, el});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] oh, ol;
    int nd, c;
    rst = 1'b1; start = 1'b0; abort = 1'b0; funct = '0; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_flags", {61'd0, busy, done, dbz}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("multu_ff", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_m3x7", 6'd24, 32'hFFFF_FFFD, 32'd7);
    run_op("div_m7_2", 6'd26, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_3", 6'd27, 32'h8000_0000, 32'd3);
    run_op("divu_z", 6'd27, 32'd100, 32'd0);
    run_op("div_z", 6'd26, 32'hFFFF_FF00, 32'd0);

    // Abort in cycle 10 of a DIV: no writeback, no done.
    wait_idle();
    oh = hi; ol = lo;
    funct = 6'd26; rs = 32'd1000; rt = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 0);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("abort_nodone", 64'(nd), 0);
    chk("abort_hilo", {hi, lo}, {oh, ol});

    // Start together with abort in IDLE is suppressed.
    funct = 6'd17; rs = 32'hDEAD_BEEF; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("abort_mthi", {32'd0, hi}, {32'd0, oh});

    funct = 6'd17; rs = 32'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("mthi", {32'd0, hi}, 64'h1234);
    chk("mthi_flags", {62'd0, busy, done}, 0);
    funct = 6'd19; rs = 32'h5678; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("mtlo", {hi, lo}, {32'h1234, 32'h5678});

    funct = 6'd0; rs = 32'hFFFF_FFFF; rt = 32'h3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("sll_ignored", {31'd0, busy, hi}, {32'd0, 32'h1234});
    chk("sll_lo", {32'd0, lo}, 64'h5678);

    // Asynchronous reset in the middle of a multiply.
    funct = 6'd25; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hilo", {hi, lo}, 0);
    chk("async_rst_flags", {61'd0, busy, done, dbz}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Start while busy is ignored; start in the done cycle is accepted.
    wait_idle();
    funct = 6'd25; rs = 32'h10; rt = 32'h20; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    funct = 6'd27; rs = 32'd99; rt = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 5;
    while (!done && c < 60) begin @(negedge clk); c++; end
    chk("busy_start_lat", 64'(c), 17);
    chk("busy_start_hilo", {hi, lo}, {32'd0, 32'h200});
    funct = 6'd27; rs = 32'd100; rt = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("b2b_busy", {62'd0, busy, done}, 2'b10);
    c = 0;
    while (!done && c < 60) begin @(negedge clk); c++; end
    chk("b2b_lat", 64'(c), 33);
    chk("b2b_hilo", {hi, lo}, {32'd2, 32'd14});

    for (int i = 0; i < 40; i++) begin
      logic [5:0] f;
      f = 6'(24 + $urandom_range(0, 3));
      run_op($sformatf("rnd%0d", i), f, pick(), pick());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes the MULT, MULTU, DIV, DIVU, MTHI and MTLO R-type functs. Multiply throughput is set by a bits-per-cycle parameter, and division is restoring radix-2. It sits beside the ALU in the execute stage: the control unit issues operations with a start pulse, stalls on `busy_o`, and reads HI/LO for MFHI/MFLO.

## Interface
- `DATA_WIDTH`, default 32: operand and HI/LO width; must be even and ≥ 4.
- `MUL_STEP`, default 2: multiplier bits retired per cycle; one of 1, 2 or 4, and must divide `DATA_WIDTH`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start_i`  in  1  issue request, sampled only in IDLE.
- `funct_i`  in  6  R-type funct code of the operation.
- `rs_i`  in  DATA_WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `rt_i`  in  DATA_WIDTH  multiplier / divisor.
- `abort_i`  in  1  exception flush; kills an in-flight operation.
- `busy_o`  out  1  high while state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse; HI/LO just updated by MULT/DIV.
- `div_by_zero_o`  out  1  qualifies `done_o`; the division had `rt_i` = 0.
- `hi_o`  out  DATA_WIDTH  HI register.
- `lo_o`  out  DATA_WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Accepted functs: MULT=24, MULTU=25, DIV=26, DIVU=27, MTHI=17, MTLO=19.
  - Any other funct, or `start_i` outside IDLE, is ignored with no state change.
- MTHI/MTLO:
  - In IDLE with `start_i`, HI (or LO) ← `rs_i` at the sampling edge.
  - State stays IDLE; no `busy_o`, no `done_o`.
- Start of MULT/MULTU/DIV/DIVU:
  - Operands are latched.
  - Signed ops convert both operands to magnitudes and record the result signs:
    - quotient/product sign = sign(rs) XOR sign(rt);
    - remainder sign = sign(rs).
  - Unsigned ops use the operands as-is, with positive signs.
- MUL:
  - N_MUL = `DATA_WIDTH`/`MUL_STEP` iterations.
  - Each iteration adds (multiplicand × next `MUL_STEP` multiplier bits) into a 2·`DATA_WIDTH` accumulator and shifts.
  - Goes to FIX after the last iteration.
- DIV:
  - N_DIV = `DATA_WIDTH` restoring iterations (shift, trial subtract, set quotient bit).
  - Goes to FIX after the last iteration.
- Divide by zero (`rt_i` = 0 at start):
  - Iterations are skipped; the unit goes straight to FIX.
  - Result is LO = all ones, HI = `rs_i`, for both DIV and DIVU.
  - `div_by_zero_o` is asserted with `done_o`.
- FIX:
  - Applies two's-complement negation per the recorded signs.
  - Writes HI/LO: product upper/lower halves, or remainder/quotient.
  - Asserts `done_o` and returns to IDLE.
- Signed overflow case: most-negative ÷ −1 gives LO = most-negative, HI = 0, with no flag.
- `abort_i` in MUL/DIV/FIX:
  - Next state is IDLE; HI/LO are not written and `done_o` is not pulsed.
  - In IDLE, `abort_i` with `start_i` suppresses the start, including MTHI/MTLO.
- `hi_o`/`lo_o` are driven directly from the registers and hold their old values while busy.

## Timing
- Reset: state IDLE; HI, LO, accumulator and sign flags are 0; `busy_o`, `done_o` and `div_by_zero_o` are 0.
  - Takes effect immediately, including mid-operation.
- Start sampled at edge 0:
  - `busy_o` goes high after edge 0.
  - FIX occupies the cycle after edge N, where N = N_MUL or N_DIV.
  - HI/LO are written and `done_o` rises after edge N+1, the same cycle `busy_o` falls.
  - Latency is N+1 edges: 17 for MUL and 33 for DIV at the default parameters.
  - Divide by zero: FIX after edge 0; done after edge 1.
- `done_o` and `div_by_zero_o` are registered one-cycle pulses.
- A new `start_i` is accepted in the cycle where `done_o` is high, giving back-to-back issue.
- An abort asserted in cycle k gives `busy_o` low after edge k.

## Test plan
- MULTU `rs`=0xFFFFFFFF, `rt`=0xFFFFFFFF → after 17 edges: HI=0xFFFFFFFE, LO=0x00000001, `done_o` for one cycle, `busy_o` high for edges 1–17.
- MULT `rs`=0xFFFFFFFD (−3), `rt`=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Repeat with `MUL_STEP`=1 and 4 to check latencies of 33 and 9 edges.
- Signed division:
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 edges.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x80000000/3 → LO=0x2AAAAAAA, HI=2.
- DIVU `rs`=100, `rt`=0 → after 1 edge: LO=0xFFFFFFFF, HI=100, `done_o`=`div_by_zero_o`=1 for one cycle.
- Abort and bypass:
  - Start DIV and pulse `abort_i` in cycle 10 → `busy_o`=0 after that edge, HI/LO unchanged, no `done_o`.
  - Then MTHI `rs`=0x1234 → `hi_o`=0x1234 after one edge, `busy_o` stays 0.
  - `start_i` with an unsupported funct (SLL) → no change.
- Reset and issue ordering:
  - Assert `rst` asynchronously mid-MUL → all outputs are 0 immediately.
  - After release, a start during busy is ignored.
  - A start in the `done_o` cycle is accepted.
